mem_port_arbiter: RTL



---
 rtl/mem_arb_defs.sv | 32 +++
 rtl/arb_pick.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_defs.sv
// Shared definitions for the memory-port arbiter: requester ids, FSM encoding, wait-counter width.
// MEM_ARB_RR_EN adds the round-robin slot helper used by arb_pick.
package mem_arb_defs;

    localparam logic [1:0] ID_IF   = 2'd0;
    localparam logic [1:0] ID_DM   = 2'd1;
    localparam logic [1:0] ID_DBG  = 2'd2;
    localparam logic [1:0] ID_NONE = 2'd3;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef MEM_ARB_RR_EN
    // (base + off) mod 3 for base in 0..2 and off in 0..3.
    function automatic logic [1:0] rr_slot(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd6) begin
            s = s - 3'd6;
        end else if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction
`endif

endpackage

// File: rtl/arb_pick.sv
// Combinational 3-way picker over IF/DM/DBG requests with a per-cycle mask.
// MEM_ARB_RR_EN: round-robin from (ptr+1) mod 3; otherwise fixed priority DBG > DM > IF.
module arb_pick
    import mem_arb_defs::*;
(
    input  logic [2:0] req,
    input  logic [2:0] mask,
`ifdef MEM_ARB_RR_EN
    input  logic [1:0] ptr,
`endif
    output logic [1:0] id,
    output logic       valid
);

    logic [2:0] elig;
    assign elig = req & ~mask;

`ifdef MEM_ARB_RR_EN
    logic [1:0] slot;

    // Walk offsets 3..1 so the slot right after ptr is assigned last and wins.
    always_comb begin
        id    = ID_NONE;
        valid = 1'b0;
        slot  = ID_NONE;
        for (int k = 3; k >= 1; k--) begin
            slot = rr_slot(ptr, 2'(k));
            if (elig[slot]) begin
                id    = slot;
                valid = 1'b1;
            end
        end
    end
`else
    always_comb begin
        id    = ID_NONE;
        valid = |elig;
        if (elig[ID_DBG]) begin
            id = ID_DBG;
        end else if (elig[ID_DM]) begin
            id = ID_DM;
        end else if (elig[ID_IF]) begin
            id = ID_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one async-read/sync-write memory between IF, DM and DBG; each access runs WAIT+1 cycles.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority DBG > DM > IF.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int AW   = 9,
    parameter int DW   = 32,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ready,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo,
    output logic          busy,
    output logic [1:0]    gnt_id,
    output state_t        fsm_state
);

    state_t           state;
    logic [1:0]       cur_id;
    logic             cur_we;
    logic [AW-1:0]    cur_addr;
    logic [DW-1:0]    cur_wdata;
    logic [CNT_W-1:0] cnt;

    logic [2:0]    mask;
    logic [1:0]    pick_id;
    logic          pick_valid;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          acc_last;

    // The requester that just completed sits out the DONE-cycle arbitration.
    assign mask = (state == S_DONE) ? (3'b001 << cur_id) : 3'b000;

`ifdef MEM_ARB_RR_EN
    logic [1:0] rr_ptr;

    arb_pick u_pick (
        .req   ({dbg_req, dm_req, if_req}),
        .mask  (mask),
        .ptr   (rr_ptr),
        .id    (pick_id),
        .valid (pick_valid)
    );
`else
    arb_pick u_pick (
        .req   ({dbg_req, dm_req, if_req}),
        .mask  (mask),
        .id    (pick_id),
        .valid (pick_valid)
    );
`endif

    // IF is read-only, so its write enable and data are never taken.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = if_addr;
        sel_wdata = '0;
        case (pick_id)
            ID_DM: begin
                sel_we    = dm_we;
                sel_addr  = dm_addr;
                sel_wdata = dm_wdata;
            end
            ID_DBG: begin
                sel_we    = dbg_we;
                sel_addr  = dbg_addr;
                sel_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    assign acc_last  = (state == S_ACC) && (cnt == '0);
    assign mem_a     = (state == S_ACC) ? cur_addr  : '0;
    assign mem_d     = (state == S_ACC) ? cur_wdata : '0;
    // Gated by rst so a reset landing on the strobe cycle never commits the write.
    assign mem_we    = rst & acc_last & cur_we;
    assign busy      = (state != S_IDLE);
    assign gnt_id    = cur_id;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cur_id    <= ID_NONE;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cnt       <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            dbg_ready <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            dbg_rdata <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr    <= ID_DBG;
`endif
        end else begin
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            dbg_ready <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (pick_valid) begin
                        state     <= S_ACC;
                        cur_id    <= pick_id;
                        cur_we    <= sel_we;
                        cur_addr  <= sel_addr;
                        cur_wdata <= sel_wdata;
                        cnt       <= CNT_W'(WAIT);
`ifdef MEM_ARB_RR_EN
                        rr_ptr    <= pick_id;
`endif
                    end else begin
                        state  <= S_IDLE;
                        cur_id <= ID_NONE;
                        cur_we <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                        case (cur_id)
                            ID_IF: begin
                                if_ready <= 1'b1;
                                if (!cur_we) if_rdata <= mem_spo;
                            end
                            ID_DM: begin
                                dm_ready <= 1'b1;
                                if (!cur_we) dm_rdata <= mem_spo;
                            end
                            ID_DBG: begin
                                dbg_ready <= 1'b1;
                                if (!cur_we) dbg_rdata <= mem_spo;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
